// File: rtl/complex_bank_ring_pkg.sv
// Shared types and helpers for the complex tile bank ring.
package complex_bank_ring_pkg;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] i;
  } complex_t;

  function automatic int unsigned bank_inc(input int unsigned idx, input int unsigned n);
    if (idx >= n - 32'd1) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/bank_ring_ctrl.sv
// Ring-buffer bookkeeping for an N-bank multi-buffer store: pointers, occupancy,
// fire qualification, registered read-bank select and read-valid.
module bank_ring_ctrl
  import complex_bank_ring_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_BITS = $clog2(NUM_BANKS),
  parameter int CNT_BITS  = $clog2(NUM_BANKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic                 wr_last,
  input  logic                 rd_req,
  input  logic                 rd_last,
  output logic                 wr_fire,
  output logic                 rd_fire,
  output logic                 wr_ready,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_BITS-1:0]  count,
  output logic [BANK_BITS-1:0] wr_bank,
  output logic [BANK_BITS-1:0] rd_bank,
  output logic [BANK_BITS-1:0] rd_sel,
  output logic                 rd_valid
);

  logic [CNT_BITS-1:0]  count_r;
  logic [CNT_BITS-1:0]  count_nxt_s;
  logic [BANK_BITS-1:0] wr_bank_r;
  logic [BANK_BITS-1:0] rd_bank_r;
  logic [BANK_BITS-1:0] rd_sel_r;
  logic                 rd_valid_r;
  logic                 commit_s;
  logic                 release_s;

  assign full     = (count_r == CNT_BITS'(NUM_BANKS));
  assign empty    = (count_r == {CNT_BITS{1'b0}});
  assign wr_ready = !full;
  assign wr_fire  = wr_valid && !full;
  assign rd_fire  = rd_req && !empty;
  assign commit_s = wr_fire && wr_last;
  assign release_s = rd_fire && rd_last;

  assign count    = count_r;
  assign wr_bank  = wr_bank_r;
  assign rd_bank  = rd_bank_r;
  assign rd_sel   = rd_sel_r;
  assign rd_valid = rd_valid_r;

  // occupancy next-state; simultaneous commit and release cancel out
  always_comb begin
    count_nxt_s = count_r;
    case ({commit_s, release_s})
      2'b10:   count_nxt_s = count_r + CNT_BITS'(1);
      2'b01:   count_nxt_s = count_r - CNT_BITS'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // pointer, occupancy and read-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r    <= {CNT_BITS{1'b0}};
      wr_bank_r  <= {BANK_BITS{1'b0}};
      rd_bank_r  <= {BANK_BITS{1'b0}};
      rd_sel_r   <= {BANK_BITS{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      rd_valid_r <= rd_fire;
      if (commit_s) begin
        wr_bank_r <= BANK_BITS'(bank_inc(32'(wr_bank_r), 32'(NUM_BANKS)));
      end
      if (release_s) begin
        rd_bank_r <= BANK_BITS'(bank_inc(32'(rd_bank_r), 32'(NUM_BANKS)));
      end
      // the mux follows the bank that was read, not the post-release pointer
      if (rd_fire) begin
        rd_sel_r <= rd_bank_r;
      end
    end
  end

endmodule

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
module dual_port_ram #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     data_out
);

  logic [WIDTH-1:0] mem_r [2**ADDR_BITS];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= data_in;
    end
    if (rd_en) begin
      data_out <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/complex_bank_ring.sv
// N-bank ring of complex tile memories: writer fills and commits banks, reader
// consumes committed banks in order and releases them.
module complex_bank_ring
  import complex_bank_ring_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int WR_ROWS    = 4,
  parameter int DEPTH_BITS = 13,
  parameter int GRP_BITS   = ((ROWS / WR_ROWS) > 1) ? $clog2(ROWS / WR_ROWS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [DEPTH_BITS-1:0]               wr_addr,
  input  logic [GRP_BITS-1:0]                 wr_group,
  input  complex_t [WR_ROWS-1:0][COLS-1:0]    wr_data,
  input  logic                                wr_last,
  input  logic                                rd_req,
  input  logic [DEPTH_BITS-1:0]               rd_addr,
  input  logic                                rd_last,
  output logic                                rd_valid,
  output complex_t [ROWS-1:0][COLS-1:0]       rd_data,
  output logic [$clog2(NUM_BANKS+1)-1:0]      count,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(NUM_BANKS)-1:0]        wr_bank,
  output logic [$clog2(NUM_BANKS)-1:0]        rd_bank
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int LANES     = ROWS * COLS;

  logic                 wr_fire_s;
  logic                 rd_fire_s;
  logic                 rd_valid_s;
  logic [BANK_BITS-1:0] wr_bank_s;
  logic [BANK_BITS-1:0] rd_bank_s;
  logic [BANK_BITS-1:0] rd_sel_s;
  logic [63:0]          ram_q_s [NUM_BANKS][LANES];

  bank_ring_ctrl #(
    .NUM_BANKS (NUM_BANKS)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_last  (wr_last),
    .rd_req   (rd_req),
    .rd_last  (rd_last),
    .wr_fire  (wr_fire_s),
    .rd_fire  (rd_fire_s),
    .wr_ready (wr_ready),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .wr_bank  (wr_bank_s),
    .rd_bank  (rd_bank_s),
    .rd_sel   (rd_sel_s),
    .rd_valid (rd_valid_s)
  );

  assign wr_bank  = wr_bank_s;
  assign rd_bank  = rd_bank_s;
  assign rd_valid = rd_valid_s;

  // one 64-bit lane RAM per (bank, row, col); a beat only enables its own row group
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar rr = 0; rr < ROWS; rr++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
        logic we_s;
        logic re_s;

        assign we_s = wr_fire_s && (wr_bank_s == BANK_BITS'(b))
                      && (wr_group == GRP_BITS'(rr / WR_ROWS));
        assign re_s = rd_fire_s && (rd_bank_s == BANK_BITS'(b));

        dual_port_ram #(
          .WIDTH     (64),
          .ADDR_BITS (DEPTH_BITS)
        ) u_ram (
          .clk      (clk),
          .we       (we_s),
          .wr_addr  (wr_addr),
          .data_in  ({wr_data[rr % WR_ROWS][c].r, wr_data[rr % WR_ROWS][c].i}),
          .rd_en    (re_s),
          .rd_addr  (rd_addr),
          .data_out (ram_q_s[b][rr*COLS + c])
        );
      end
    end
  end

  // output word from the bank captured at read time, zero when not valid
  always_comb begin
    rd_data = {(LANES*64){1'b0}};
    if (rd_valid_s) begin
      for (int rr = 0; rr < ROWS; rr++) begin
        for (int c = 0; c < COLS; c++) begin
          rd_data[rr][c] = ram_q_s[rd_sel_s][rr*COLS + c];
        end
      end
    end else begin
      rd_data = {(LANES*64){1'b0}};
    end
  end

endmodule

// File: tb/tb_complex_bank_ring.sv
// Directed table-driven bench for complex_bank_ring (3 banks, half-height write beats).
module tb_complex_bank_ring;
  import complex_bank_ring_pkg::*;

  localparam int NB = 3;
  localparam int RW = 4;
  localparam int CL = 4;
  localparam int WRR = 2;
  localparam int DB = 4;
  localparam int GB = 1;
  localparam int BB = 2;
  localparam int CB = 2;

  logic                        clk;
  logic                        rst;
  logic                        wr_valid;
  logic                        wr_ready;
  logic [DB-1:0]               wr_addr;
  logic [GB-1:0]               wr_group;
  complex_t [WRR-1:0][CL-1:0]  wr_data;
  logic                        wr_last;
  logic                        rd_req;
  logic [DB-1:0]               rd_addr;
  logic                        rd_last;
  logic                        rd_valid;
  complex_t [RW-1:0][CL-1:0]   rd_data;
  logic [CB-1:0]               count;
  logic                        full;
  logic                        empty;
  logic [BB-1:0]               wr_bank;
  logic [BB-1:0]               rd_bank;

  int errors = 0;
  int checks = 0;

  complex_bank_ring #(
    .NUM_BANKS  (NB),
    .ROWS       (RW),
    .COLS       (CL),
    .WR_ROWS    (WRR),
    .DEPTH_BITS (DB),
    .GRP_BITS   (GB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_group (wr_group),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_last  (rd_last),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .wr_bank  (wr_bank),
    .rd_bank  (rd_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int wv; int wg; int wl; int wt; int wa;
    int rq; int rl; int ra;
    int cnt; int wb; int rb; int rv; int tlo; int thi;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int wv, input int wg, input int wl, input int wt, input int wa,
                              input int rq, input int rl, input int ra,
                              input int cnt, input int wb, input int rb, input int rv,
                              input int tlo, input int thi);
    vec_t v;
    v.wv = wv; v.wg = wg; v.wl = wl; v.wt = wt; v.wa = wa;
    v.rq = rq; v.rl = rl; v.ra = ra;
    v.cnt = cnt; v.wb = wb; v.rb = rb; v.rv = rv; v.tlo = tlo; v.thi = thi;
    vecs.push_back(v);
  endfunction

  // lane value: r carries tag and address, i carries the lane number
  function automatic complex_t pat(input int tag, input int addr, input int lane);
    complex_t x;
    x.r = 32'(tag * 65536 + addr);
    x.i = 32'(lane);
    return x;
  endfunction

  function automatic logic [RW*CL*64-1:0] exp_data(input int rv, input int addr, input int tlo, input int thi);
    complex_t [RW-1:0][CL-1:0] d;
    d = {(RW*CL*64){1'b0}};
    if (rv != 0) begin
      for (int r = 0; r < RW; r++)
        for (int c = 0; c < CL; c++)
          d[r][c] = pat((r < 2) ? tlo : thi, addr, r*CL + c);
    end
    return d;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [RW*CL*64-1:0] exp);
    logic [RW*CL*64-1:0] act;
    act = rd_data;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int l = 0; l < RW*CL; l++) begin
        if (act[l*64 +: 64] !== exp[l*64 +: 64]) begin
          $display("FAIL %s: lane %0d got %h expected %h", nm, l, act[l*64 +: 64], exp[l*64 +: 64]);
          break;
        end
      end
    end
  endtask

  task automatic apply(input vec_t v);
    wr_valid = (v.wv != 0);
    wr_group = GB'(v.wg);
    wr_last  = (v.wl != 0);
    wr_addr  = DB'(v.wa);
    for (int r = 0; r < WRR; r++)
      for (int c = 0; c < CL; c++)
        wr_data[r][c] = pat(v.wt, v.wa, (v.wg*WRR + r)*CL + c);
    rd_req  = (v.rq != 0);
    rd_last = (v.rl != 0);
    rd_addr = DB'(v.ra);
  endtask

  task automatic chk_state(input string p, input int cnt, input int wb, input int rb, input int rv);
    chk({p, " count"}, int'(count), cnt);
    chk({p, " full"}, int'(full), (cnt == NB) ? 1 : 0);
    chk({p, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
    chk({p, " wr_ready"}, int'(wr_ready), (cnt == NB) ? 0 : 1);
    chk({p, " wr_bank"}, int'(wr_bank), wb);
    chk({p, " rd_bank"}, int'(rd_bank), rb);
    chk({p, " rd_valid"}, int'(rd_valid), rv);
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_group = '0; wr_last = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_last = 1'b0; rd_addr = '0;

    //   wv wg wl wt wa  rq rl ra  cnt wb rb rv tlo thi
    // fill bank 0, addresses 0..3, two half beats each, commit on the last
    add(1, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 2,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 2,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 3,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 3,  0, 0, 0,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0,  1, 1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0,  1, 0, 1,  1, 1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0,  1, 0, 2,  1, 1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0,  1, 0, 3,  1, 1, 0, 1, 1, 1);
    // bank 1 addr 5: group 0 tag 2, group 1 tag 3, commit
    add(1, 0, 0, 2, 5,  0, 0, 0,  1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 3, 5,  0, 0, 0,  2, 2, 0, 0, 0, 0);
    // bank 2 addr 5: full word tag 4, then group 0 only tag 5 with commit -> full, wb wraps
    add(1, 0, 0, 4, 5,  0, 0, 0,  2, 2, 0, 0, 0, 0);
    add(1, 1, 0, 4, 5,  0, 0, 0,  2, 2, 0, 0, 0, 0);
    add(1, 0, 1, 5, 5,  0, 0, 0,  3, 0, 0, 0, 0, 0);
    // write while full is dropped
    add(1, 0, 1, 6, 0,  0, 0, 0,  3, 0, 0, 0, 0, 0);
    // release bank 0, rewrite bank 0 addr 0 with tag 7
    add(0, 0, 0, 0, 0,  1, 1, 0,  2, 0, 1, 1, 1, 1);
    add(1, 0, 0, 7, 0,  0, 0, 0,  2, 0, 1, 0, 0, 0);
    add(1, 1, 1, 7, 0,  0, 0, 0,  3, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 5,  2, 1, 2, 1, 2, 3);
    add(0, 0, 0, 0, 0,  1, 1, 5,  1, 1, 0, 1, 5, 4);
    // commit and release together at count 1
    add(1, 0, 1, 8, 2,  1, 1, 0,  1, 2, 1, 1, 7, 7);
    add(0, 0, 0, 0, 0,  1, 1, 5,  0, 2, 2, 1, 2, 3);
    // read with last while empty
    add(0, 0, 0, 0, 0,  1, 1, 0,  0, 2, 2, 0, 0, 0);
    // two commits to reach count 2
    add(1, 0, 1, 9, 0,  0, 0, 0,  1, 0, 2, 0, 0, 0);
    add(1, 0, 1, 9, 0,  0, 0, 0,  2, 1, 2, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 0, 0);
    chk_data("reset rd_data", exp_data(0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].wb, vecs[i].rb, vecs[i].rv);
      chk_data($sformatf("v%0d rd_data", i), exp_data(vecs[i].rv, vecs[i].ra, vecs[i].tlo, vecs[i].thi));
    end

    // reset while a read is in flight with two banks committed
    wr_valid = 1'b0; wr_last = 1'b0;
    rd_req = 1'b1; rd_last = 1'b0; rd_addr = '0;
    @(posedge clk);
    #1;
    chk("pre-reset rd_valid", int'(rd_valid), 1);
    rd_req = 1'b0;
    rst = 1'b1;
    #1;
    chk_state("mid reset", 0, 0, 0, 0);
    chk_data("mid reset rd_data", exp_data(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    rd_req = 1'b1; rd_last = 1'b1;
    @(posedge clk);
    #1;
    chk_state("post reset read", 0, 0, 0, 0);
    chk_data("post reset rd_data", exp_data(0, 0, 0, 0));
    rd_req = 1'b0; rd_last = 1'b0;
    @(posedge clk);
    #1;
    chk("post reset idle rd_valid", int'(rd_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
